issue_req_ctrl: RTL and testbench
=================================

// Module: issue_req_ctrl
// PURPOSE
//  Per-entry request generator for the issue-queue select tree; sits directly upstream of the select blocks.
//  Tracks each IQ entry's scheduling state and drives the request vector into the select tree.
//  Consumes the one-hot grant returned by the tree and registers the winner's index for the payload-read stage.
//  Handles replay, free, stall and flush.
// PARAMETERS
//  IQ_SIZE  16                 number of IQ entries; equals the request width of the select tree it feeds
//  IDX_W    $clog2(IQ_SIZE)    width of an entry index
// PORTS
//  clk              in   1          clock; all state updates on the rising edge
//  reset            in   1          asynchronous, active-high reset
//  flush_i          in   1          squash all entries
//  stall_i          in   1          downstream payload read stalled; suppresses requests
//  alloc_valid_i    in   IQ_SIZE    entries written by dispatch this cycle
//  alloc_ready_i    in   IQ_SIZE    allocated entry has all operands ready
//  wakeup_i         in   IQ_SIZE    entry's last outstanding operand becomes ready this cycle
//  grant_i          in   IQ_SIZE    one-hot grant from the select tree; same cycle as req_o
//  replay_i         in   IQ_SIZE    issued entry must re-issue (e.g. load miss)
//  free_i           in   IQ_SIZE    entry leaves the queue
//  req_o            out  IQ_SIZE    request vector to the select tree
//  issue_valid_o    out  1          registered: an entry was granted last cycle
//  issue_idx_o      out  IDX_W      registered index of that entry
//  occupancy_o      out  IDX_W+1    registered count of non-EMPTY entries
//  error_o          out  1          sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (async): all entries EMPTY. req_o=0, issue_valid_o=0, issue_idx_o=0, occupancy_o=0, error_o=0.
//  - Per-entry 2-bit state: EMPTY, WAIT, READY, ISSUED.
//    Per-entry event priority: flush > free > replay > grant > wakeup > alloc.
//  - EMPTY  --alloc--> READY if (alloc_ready_i | wakeup_i), else WAIT.
//  - WAIT   --wakeup--> READY.
//  - READY  --grant & req_o--> ISSUED.
//  - ISSUED --replay--> WAIT.
//  - any non-EMPTY --free--> EMPTY.
//  - flush_i: every entry is EMPTY next cycle.
//  - Events with no matching transition are no-ops: wakeup on READY/ISSUED; grant on a non-requesting entry.
//  - req_o[i] = (state[i]==READY) & ~stall_i & ~flush_i.
//    Decoded from registered state only; there is no combinational path from grant_i, so the loop is broken.
//  - Latency: alloc with ready=1 in cycle N -> req_o bit set in N+1.
//    Wakeup in N -> req in N+1.
//    Grant in N -> issue_valid_o/issue_idx_o in N+1, and the req bit drops in N+1.
//  - issue_valid_o next = |(grant_i & req_o) & ~flush_i.
//    issue_idx_o next = index of the granted bit; it holds its previous value when there is no grant.
//  - occupancy_o next = popcount of non-EMPTY next-states; range 0..IQ_SIZE, never wraps.
//  - error_o: set, and held until reset, on any of the following.
//    Each offending event is otherwise ignored, except multi-hot grant (see below).
//      alloc to a non-EMPTY entry; replay to a non-ISSUED entry;
//      grant_i bit set where req_o=0; grant_i not one-hot or zero.
//    Multi-hot grant: the lowest-index requesting bit is taken.
//  - Simultaneous alloc+free on the same entry: free wins, entry EMPTY, error_o set.
//  - Reset asserted mid-operation: all state clears immediately, no pending issue is reported.
// STRUCTURE
//  - Shared issue package holds:
//      entry_state_t enum (EMPTY=2'b00, WAIT=2'b01, READY=2'b10, ISSUED=2'b11);
//      the IQ_SIZE default; the IDX_W derivation.
//  - Sub-module onehot_to_index (param WIDTH): lowest-set-bit index plus any/multi flags.
//    Instanced once for the grant.
//  - Per-entry next-state logic is written as a generate loop.
//  - Popcount is a plain adder reduction inside this module.
// TESTING
//  1. Reset pulse mid-run with 5 entries live
//     -> same-cycle outputs: req_o=0, issue_valid_o=0, occupancy_o=0, error_o=0.
//  2. alloc_valid_i=0x0008, alloc_ready_i=0x0008 -> next cycle req_o=0x0008;
//     drive grant_i=0x0008 -> next cycle issue_valid_o=1, issue_idx_o=3, req_o=0.
//  3. alloc entry 5 with ready=0 -> req_o[5]=0 for 4 cycles;
//     wakeup_i=0x0020 -> next cycle req_o=0x0020.
//  4. Entries 1,2 READY with stall_i=1 -> req_o=0;
//     release stall -> req_o=0x0006, occupancy_o=2.
//  5. Entry 3 ISSUED, replay_i=0x0008 -> WAIT, req_o[3]=0;
//     wakeup -> req again; grant, then free_i=0x0008 -> occupancy_o decrements by 1.
//  6. 4 entries READY, flush_i=1 with grant_i=0x0001 -> req_o=0 that cycle;
//     next cycle occupancy_o=0, issue_valid_o=0.
//     Separately, grant_i=0x0003 -> error_o=1 and stays 1.

Source files
------------

// File: rtl/issue_req_ctrl_pkg.sv
// Shared issue-queue types and sizing helpers for the request controller and its
// grant decoder.
package issue_req_ctrl_pkg;

  localparam int unsigned IqSizeDefault = 16;

  // An index must be at least one bit wide, even for a degenerate single-entry queue.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    StEmpty  = 2'b00,
    StWait   = 2'b01,
    StReady  = 2'b10,
    StIssued = 2'b11
  } entry_state_t;

endpackage

// File: rtl/issue_req_ctrl_onehot.sv
// Grant decoder: index of the lowest set bit, plus any-set and more-than-one-set
// flags.
module onehot_to_index
  import issue_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = IqSizeDefault,
  parameter int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |vec_i;
  assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule

// File: rtl/issue_req_ctrl.sv
// Per-entry issue-queue request generator. It tracks the scheduling state of each
// entry and drives the select-tree request vector. It registers the index of the
// granted entry for the payload-read stage.
module issue_req_ctrl
  import issue_req_ctrl_pkg::*;
#(
  parameter int unsigned IQ_SIZE = IqSizeDefault,
  parameter int unsigned IDX_W   = idx_width(IQ_SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [IQ_SIZE-1:0] alloc_valid_i,
  input  logic [IQ_SIZE-1:0] alloc_ready_i,
  input  logic [IQ_SIZE-1:0] wakeup_i,
  input  logic [IQ_SIZE-1:0] grant_i,
  input  logic [IQ_SIZE-1:0] replay_i,
  input  logic [IQ_SIZE-1:0] free_i,
  output logic [IQ_SIZE-1:0] req_o,
  output logic               issue_valid_o,
  output logic [IDX_W-1:0]   issue_idx_o,
  output logic [IDX_W:0]     occupancy_o,
  output logic               error_o
);

  logic [IQ_SIZE-1:0] empty_q, ready_q, issued_q, live_d;
  logic [IQ_SIZE-1:0] gnt_vld, grant_sel;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any, gnt_multi, err_evt;

  logic               issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
  logic [IDX_W:0]     occupancy_q, occupancy_d;
  logic               error_q, error_d;

  // Decoded from registered state only; grant_i never reaches req_o.
  assign req_o   = ready_q & {IQ_SIZE{~stall_i & ~flush_i}};
  assign gnt_vld = grant_i & req_o;

  onehot_to_index #(
    .WIDTH (IQ_SIZE),
    .IDX_W (IDX_W)
  ) u_grant_dec (
    .vec_i   (gnt_vld),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any),
    .multi_o (gnt_multi)
  );

  // On a multi-hot grant, only the lowest requesting entry moves to issued.
  assign grant_sel = gnt_any ? (IQ_SIZE'(1) << gnt_idx) : '0;

  for (genvar g = 0; g < IQ_SIZE; g++) begin : g_entry
    entry_state_t st_q, st_d;

    // Priority: flush > free > replay > grant > wakeup > alloc.
    always_comb begin
      st_d = st_q;
      if (flush_i || free_i[g]) begin
        st_d = StEmpty;
      end else if (replay_i[g] && (st_q == StIssued)) begin
        st_d = StWait;
      end else if (grant_sel[g]) begin
        st_d = StIssued;
      end else if (wakeup_i[g] && (st_q == StWait)) begin
        st_d = StReady;
      end else if (alloc_valid_i[g] && (st_q == StEmpty)) begin
        st_d = (alloc_ready_i[g] || wakeup_i[g]) ? StReady : StWait;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) st_q <= StEmpty;
      else       st_q <= st_d;
    end

    assign empty_q[g]  = (st_q == StEmpty);
    assign ready_q[g]  = (st_q == StReady);
    assign issued_q[g] = (st_q == StIssued);
    assign live_d[g]   = (st_d != StEmpty);
  end

  // A flush squashes every other event in its cycle, including protocol violations.
  assign err_evt = (|(alloc_valid_i & ~empty_q)) | (|(replay_i & ~issued_q)) |
                   (|(grant_i & ~req_o)) | gnt_multi | (|(alloc_valid_i & free_i));

  always_comb begin
    issue_valid_d = gnt_any & ~flush_i;
    issue_idx_d   = gnt_any ? gnt_idx : issue_idx_q;
    error_d       = error_q | (err_evt & ~flush_i);
    occupancy_d   = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      occupancy_d = occupancy_d + (IDX_W + 1)'(live_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      occupancy_q   <= '0;
      error_q       <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      occupancy_q   <= occupancy_d;
      error_q       <= error_d;
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_idx_o   = issue_idx_q;
  assign occupancy_o   = occupancy_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_issue_req_ctrl.sv
// Scoreboard bench for issue_req_ctrl. The stimulus queues hand-computed expectations
// tagged with a cycle number. A negedge monitor pops each one and compares it.
module tb_issue_req_ctrl;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_i = 1'b0, stall_i = 1'b0;
  logic [N-1:0]  alloc_valid_i = '0, alloc_ready_i = '0, wakeup_i = '0;
  logic [N-1:0]  grant_i = '0, replay_i = '0, free_i = '0;
  logic [N-1:0]  req_o;
  logic          issue_valid_o;
  logic [3:0]    issue_idx_o;
  logic [4:0]    occupancy_o;
  logic          error_o;

  issue_req_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_i (alloc_ready_i),
    .wakeup_i      (wakeup_i),
    .grant_i       (grant_i),
    .replay_i      (replay_i),
    .free_i        (free_i),
    .req_o         (req_o),
    .issue_valid_o (issue_valid_o),
    .issue_idx_o   (issue_idx_o),
    .occupancy_o   (occupancy_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] MReq = 5'b00001, MIv = 5'b00010, MIdx = 5'b00100;
  localparam logic [4:0] MOcc = 5'b01000, MErr = 5'b10000, MAll = 5'b11111;

  typedef struct {
    int         cyc;
    int         tag;
    logic [4:0] mask;
    logic [N-1:0] req;
    logic       iv;
    logic [3:0] idx;
    logic [4:0] occ;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s test %0d cycle %0d: got %0h want %0h", name, tag, cyc, got, want);
    end
  endtask

  // Monitor: compares every expectation that falls due in this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc) begin
        chk("stale_expectation", mon_e.tag, 32'(cyc), 32'(mon_e.cyc));
      end else begin
        if (mon_e.mask[0]) chk("req_o", mon_e.tag, 32'(req_o), 32'(mon_e.req));
        if (mon_e.mask[1]) chk("issue_valid_o", mon_e.tag, 32'(issue_valid_o), 32'(mon_e.iv));
        if (mon_e.mask[2]) chk("issue_idx_o", mon_e.tag, 32'(issue_idx_o), 32'(mon_e.idx));
        if (mon_e.mask[3]) chk("occupancy_o", mon_e.tag, 32'(occupancy_o), 32'(mon_e.occ));
        if (mon_e.mask[4]) chk("error_o", mon_e.tag, 32'(error_o), 32'(mon_e.err));
      end
    end
  end

  task automatic exp_now(input int tag, input logic [4:0] mask, input logic [N-1:0] req,
                         input logic iv, input logic [3:0] idx, input logic [4:0] occ,
                         input logic err);
    exp_t e;
    e.cyc = cyc; e.tag = tag; e.mask = mask; e.req = req;
    e.iv = iv; e.idx = idx; e.occ = occ; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    exp_now(0, MAll, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Allocate entry 3 as ready, then grant it.
    alloc_valid_i = 16'h0008; alloc_ready_i = 16'h0008;
    step();
    alloc_valid_i = '0; alloc_ready_i = '0;
    exp_now(2, MReq | MIv | MOcc, 16'h0008, 1'b0, 4'd0, 5'd1, 1'b0);
    grant_i = 16'h0008;
    step();
    grant_i = '0;
    exp_now(2, MAll, '0, 1'b1, 4'd3, 5'd1, 1'b0);

    // Replay entry 3, wake it, grant it again, then free it.
    replay_i = 16'h0008;
    step();
    replay_i = '0;
    exp_now(5, MReq | MOcc | MErr, '0, 1'b0, 4'd0, 5'd1, 1'b0);
    wakeup_i = 16'h0008;
    step();
    wakeup_i = '0;
    exp_now(5, MReq, 16'h0008, 1'b0, 4'd0, 5'd0, 1'b0);
    grant_i = 16'h0008;
    step();
    grant_i = '0;
    exp_now(5, MReq | MIv | MIdx, '0, 1'b1, 4'd3, 5'd0, 1'b0);
    free_i = 16'h0008;
    step();
    free_i = '0;
    exp_now(5, MReq | MIv | MOcc, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Allocate entry 5 not ready: it waits 4 cycles, then a wakeup makes it request.
    alloc_valid_i = 16'h0020;
    step();
    alloc_valid_i = '0;
    for (int k = 0; k < 4; k++) begin
      exp_now(3, MReq | MOcc, '0, 1'b0, 4'd0, 5'd1, 1'b0);
      if (k == 3) wakeup_i = 16'h0020;
      else step();
    end
    step();
    wakeup_i = '0;
    exp_now(3, MReq, 16'h0020, 1'b0, 4'd0, 5'd1, 1'b0);
    grant_i = 16'h0020;
    step();
    grant_i = '0;
    exp_now(3, MReq | MIv | MIdx, '0, 1'b1, 4'd5, 5'd1, 1'b0);
    free_i = 16'h0020;
    step();
    free_i = '0;
    exp_now(3, MOcc, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Stall masks requests from ready entries 1 and 2.
    alloc_valid_i = 16'h0006; alloc_ready_i = 16'h0006; stall_i = 1'b1;
    step();
    alloc_valid_i = '0; alloc_ready_i = '0;
    exp_now(4, MReq | MOcc, '0, 1'b0, 4'd0, 5'd2, 1'b0);
    step();
    exp_now(4, MReq, '0, 1'b0, 4'd0, 5'd2, 1'b0);
    step();
    stall_i = 1'b0;
    exp_now(4, MReq | MOcc, 16'h0006, 1'b0, 4'd0, 5'd2, 1'b0);
    grant_i = 16'h0002;
    step();
    grant_i = 16'h0004;
    exp_now(4, MReq | MIv | MIdx, 16'h0004, 1'b1, 4'd1, 5'd0, 1'b0);
    step();
    grant_i = '0;
    exp_now(4, MAll, '0, 1'b1, 4'd2, 5'd2, 1'b0);
    free_i = 16'h0006;
    step();
    free_i = '0;
    exp_now(6, MOcc, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Four ready entries, then a flush with a grant in the same cycle.
    alloc_valid_i = 16'h000F; alloc_ready_i = 16'h000F;
    step();
    alloc_valid_i = '0; alloc_ready_i = '0;
    exp_now(6, MReq | MOcc | MErr, 16'h000F, 1'b0, 4'd0, 5'd4, 1'b0);
    step();
    flush_i = 1'b1; grant_i = 16'h0001;
    exp_now(6, MReq, '0, 1'b0, 4'd0, 5'd0, 1'b0);
    step();
    flush_i = 1'b0; grant_i = '0;
    exp_now(6, MReq | MIv | MOcc, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Multi-hot grant: lowest requester wins, and the sticky error flag is set.
    alloc_valid_i = 16'h001F; alloc_ready_i = 16'h001F;
    step();
    alloc_valid_i = '0; alloc_ready_i = '0;
    exp_now(7, MReq | MOcc | MErr, 16'h001F, 1'b0, 4'd0, 5'd5, 1'b0);
    step();
    grant_i = 16'h0003;
    step();
    grant_i = '0;
    exp_now(7, MAll, 16'h001E, 1'b1, 4'd0, 5'd5, 1'b1);
    step();
    exp_now(7, MIv | MOcc | MErr, '0, 1'b0, 4'd0, 5'd5, 1'b1);

    // Asynchronous reset with 5 entries live clears every output in the same cycle.
    step();
    reset = 1'b1;
    exp_now(1, MAll, '0, 1'b0, 4'd0, 5'd0, 1'b0);
    step();
    reset = 1'b0;
    step();
    exp_now(1, MAll, '0, 1'b0, 4'd0, 5'd0, 1'b0);

    // Alloc with a coincident wakeup goes straight to ready. Re-alloc of a live entry is an error.
    alloc_valid_i = 16'h0041; alloc_ready_i = 16'h0001; wakeup_i = 16'h0040;
    step();
    alloc_valid_i = 16'h0001; alloc_ready_i = '0; wakeup_i = '0;
    exp_now(8, MReq | MOcc | MErr, 16'h0041, 1'b0, 4'd0, 5'd2, 1'b0);
    step();
    alloc_valid_i = '0;
    exp_now(8, MReq | MOcc | MErr, 16'h0041, 1'b0, 4'd0, 5'd2, 1'b1);

    // A replay to an entry that was never issued is an error.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    replay_i = 16'h0001;
    step();
    replay_i = '0;
    exp_now(9, MReq | MOcc | MErr, '0, 1'b0, 4'd0, 5'd0, 1'b1);

    step();
    step();
    chk("scoreboard_drained", 10, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
